ram_req_arbiter: RTL

- Round-robin arbiter that shares a single SDRAM/UMA RAM port between N requesters, e.g. the NEXTOR/TF loader, the flash boot copier and the CPU-side memory mapper.
- Sits between the requesters and one UMA secondary RAM port.
- Serialises accesses and latches request fields.
- Returns per-requester acknowledge and read data, with a timeout so a dead RAM port cannot hang the bus.

---
 rtl/ram_req_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/ram_req_arbiter.sv
// Round-robin arbiter sharing one UMA/SDRAM RAM port between N requesters.
// Latches the winner's request fields, waits for RAM_ACK (with timeout) and pulses ACK.
module ram_req_arbiter #(
    parameter int unsigned N          = 2,
    parameter int unsigned ADDR_WIDTH = 23,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned PRIO0      = 0,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic [N-1:0]                 REQ,
    input  logic [N*ADDR_WIDTH-1:0]      ADDR,
    input  logic [N*DATA_WIDTH-1:0]      DIN,
    input  logic [N-1:0]                 WE,
    input  logic [N*BE_WIDTH-1:0]        BE,
    output logic [N-1:0]                 ACK,
    output logic [DATA_WIDTH-1:0]        DOUT,
    output logic                         ERR,
    output logic                         BUSY,
    output logic                         RAM_REQ,
    output logic [ADDR_WIDTH-1:0]        RAM_ADDR,
    output logic [DATA_WIDTH-1:0]        RAM_DIN,
    output logic                         RAM_WE,
    output logic [BE_WIDTH-1:0]          RAM_BE,
    input  logic                         RAM_ACK,
    input  logic [DATA_WIDTH-1:0]        RAM_DOUT
);

    localparam int unsigned GW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [GW-1:0]         grant;
    logic [GW-1:0]         last_grant;
    logic [GW-1:0]         pick;
    logic                  found;
    logic [N-1:0]          elig;
    logic                  mask_last;
    logic [TW-1:0]         tcnt;
    logic                  do_grant;
    logic                  do_ok;
    logic                  do_timeout;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_din;
    logic                  sel_we;
    logic [BE_WIDTH-1:0]   sel_be;

    // Winner selection: optional absolute priority for 0, else search after last_grant.
    always_comb begin
        int idx;
        idx   = 0;
        elig  = REQ;
        if (mask_last) begin
            elig[last_grant] = 1'b0;
        end
        pick  = '0;
        found = 1'b0;
        if (PRIO0 != 0 && elig[0]) begin
            found = 1'b1;
        end
        for (int k = 1; k <= int'(N); k++) begin
            idx = (int'(last_grant) + k) % int'(N);
            if (!found && elig[GW'(idx)]) begin
                pick  = GW'(idx);
                found = 1'b1;
            end
        end
    end

    // Request field mux for the selected requester.
    always_comb begin
        sel_addr = '0;
        sel_din  = '0;
        sel_we   = 1'b0;
        sel_be   = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (pick == GW'(i)) begin
                sel_addr = ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_din  = DIN[i*DATA_WIDTH +: DATA_WIDTH];
                sel_we   = WE[i];
                sel_be   = BE[i*BE_WIDTH +: BE_WIDTH];
            end
        end
    end

    // Next-state and transaction events.
    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        do_ok      = 1'b0;
        do_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    do_grant   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (RAM_ACK) begin
                    do_ok      = 1'b1;
                    state_next = DONE;
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    do_timeout = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered outputs, latched RAM request fields and arbitration history.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ACK        <= '0;
            DOUT       <= '0;
            ERR        <= 1'b0;
            BUSY       <= 1'b0;
            RAM_REQ    <= 1'b0;
            RAM_ADDR   <= '0;
            RAM_DIN    <= '0;
            RAM_WE     <= 1'b0;
            RAM_BE     <= '0;
            grant      <= '0;
            last_grant <= GW'(N - 1);
            mask_last  <= 1'b0;
            tcnt       <= '0;
        end else begin
            ACK       <= '0;
            BUSY      <= (state_next != IDLE);
            // The idle cycle right after a completion ignores the requester just served.
            mask_last <= (state == DONE);
            if (do_grant) begin
                grant      <= pick;
                last_grant <= pick;
                tcnt       <= '0;
                RAM_REQ    <= 1'b1;
                RAM_ADDR   <= sel_addr;
                RAM_DIN    <= sel_din;
                RAM_WE     <= sel_we;
                RAM_BE     <= sel_be;
            end
            if (state == ISSUE && !do_ok && !do_timeout) begin
                tcnt <= tcnt + TW'(1);
            end
            if (do_ok) begin
                DOUT       <= RAM_DOUT;
                ERR        <= 1'b0;
                RAM_REQ    <= 1'b0;
                ACK[grant] <= 1'b1;
            end
            if (do_timeout) begin
                DOUT       <= '0;
                ERR        <= 1'b1;
                RAM_REQ    <= 1'b0;
                ACK[grant] <= 1'b1;
            end
        end
    end

endmodule
